// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock-setting controller: mode encodings and
// default timing parameters.
package clock_set_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_SETH = 2'd1,
      ST_SETM = 2'd2
   } state_t;

   localparam int DIV_DEFAULT     = 32'd32768;
   localparam int REP_DLY_DEFAULT = 32'd4;
   localparam int REP_PER_DEFAULT = 32'd1;

endpackage

// File: rtl/clock_set_ctrl_tick_gen.sv
// Prescaler: counts CLK cycles 0..DIV-1 and flags each 1/8-second subtick
// and the once-per-second tick on the last count of each period.
module tick_gen
   import clock_set_ctrl_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   output logic SUBTICK,
   output logic SECTICK
);

   localparam int SUB = DIV / 8;
   localparam int PW  = $clog2(DIV);
   localparam int SW  = $clog2(SUB);

   localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
   localparam logic [SW-1:0] SUB_LAST  = SW'(SUB - 1);

   logic [PW-1:0] pcnt_r;
   logic [SW-1:0] sub_r;

   // Second and subtick counters; the subtick counter rolls over in step with PCNT
   always_ff @(posedge CLK) begin
      if (RST || CLR) begin
         pcnt_r <= {PW{1'b0}};
         sub_r  <= {SW{1'b0}};
      end else begin
         pcnt_r <= (pcnt_r == PCNT_LAST) ? {PW{1'b0}} : pcnt_r + PW'(1'b1);
         sub_r  <= (sub_r == SUB_LAST) ? {SW{1'b0}} : sub_r + SW'(1'b1);
      end
   end

   assign SUBTICK = (sub_r == SUB_LAST);
   assign SECTICK = (pcnt_r == PCNT_LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: RUN/SETH/SETM mode FSM, set-button auto-repeat,
// blink blanking of the digits being set and the seconds-counter enable.
module clock_set_ctrl
   import clock_set_ctrl_pkg::*;
#(
   parameter int DIV     = DIV_DEFAULT,
   parameter int REP_DLY = REP_DLY_DEFAULT,
   parameter int REP_PER = REP_PER_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       MODE,
   input  logic       UP,
   output logic       SECEN,
   output logic       SECCLR,
   output logic       MININC,
   output logic       HOURINC,
   output logic       BLANKH,
   output logic       BLANKM,
   output logic [1:0] STATE
);

   localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [REP_W-1:0] REP_DLY_C = REP_W'(REP_DLY);
   localparam logic [REP_W-1:0] REP_PER_C = REP_W'(REP_PER);

   state_t           state_r, state_next_s;
   logic             mode_prev_r, up_prev_r;
   logic             mode_rise_s, up_rise_s, set_mode_s;
   logic             subtick_s, sectick_s, clr_s;
   logic             rep_act_r, rep_act_next_s;
   logic             rep_run_r, rep_run_next_s;
   logic [REP_W-1:0] rep_cnt_r, rep_cnt_next_s, rep_target_s;
   logic             inc_s;
   logic [1:0]       blink_cnt_r, blink_cnt_next_s;
   logic             blink_off_r, blink_off_next_s;
   logic             secen_r, secclr_r, mininc_r, hourinc_r, blankh_r, blankm_r;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .CLK     (CLK),
      .RST     (RST),
      .CLR     (clr_s),
      .SUBTICK (subtick_s),
      .SECTICK (sectick_s)
   );

   assign mode_rise_s  = MODE & ~mode_prev_r;
   assign up_rise_s    = UP & ~up_prev_r;
   assign set_mode_s   = (state_r == ST_SETH) || (state_r == ST_SETM);
   assign clr_s        = (state_r == ST_SETM) && mode_rise_s;
   assign rep_target_s = rep_run_r ? REP_PER_C : REP_DLY_C;

   // Mode sequencing; an unexpected encoding falls back to RUN
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RUN:  state_next_s = mode_rise_s ? ST_SETH : ST_RUN;
         ST_SETH: state_next_s = mode_rise_s ? ST_SETM : ST_SETH;
         ST_SETM: state_next_s = mode_rise_s ? ST_RUN  : ST_SETM;
         default: state_next_s = ST_RUN;
      endcase
   end

   // Increment request and auto-repeat; a MODE edge outranks UP and kills any pending repeat
   always_comb begin
      inc_s          = 1'b0;
      rep_act_next_s = rep_act_r;
      rep_run_next_s = rep_run_r;
      rep_cnt_next_s = rep_cnt_r;
      if (mode_rise_s || !UP || !set_mode_s) begin
         rep_act_next_s = 1'b0;
         rep_run_next_s = 1'b0;
         rep_cnt_next_s = {REP_W{1'b0}};
      end else if (up_rise_s) begin
         inc_s          = 1'b1;
         rep_act_next_s = 1'b1;
         rep_run_next_s = 1'b0;
         rep_cnt_next_s = {REP_W{1'b0}};
      end else if (rep_act_r && subtick_s) begin
         if ((rep_cnt_r + REP_W'(1'b1)) == rep_target_s) begin
            inc_s          = 1'b1;
            rep_run_next_s = 1'b1;
            rep_cnt_next_s = {REP_W{1'b0}};
         end else begin
            rep_cnt_next_s = rep_cnt_r + REP_W'(1'b1);
         end
      end else begin
         rep_cnt_next_s = rep_cnt_r;
      end
   end

   // Blink phase: restarts "on" after any increment or mode change, flips every 4 subticks
   always_comb begin
      blink_cnt_next_s = blink_cnt_r;
      blink_off_next_s = blink_off_r;
      if (inc_s || (state_next_s != state_r)) begin
         blink_cnt_next_s = 2'd0;
         blink_off_next_s = 1'b0;
      end else if (subtick_s) begin
         if (blink_cnt_r == 2'd3) begin
            blink_cnt_next_s = 2'd0;
            blink_off_next_s = ~blink_off_r;
         end else begin
            blink_cnt_next_s = blink_cnt_r + 2'd1;
         end
      end else begin
         blink_cnt_next_s = blink_cnt_r;
      end
   end

   // State, edge history, counters and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= ST_RUN;
         mode_prev_r <= 1'b1;
         up_prev_r   <= 1'b1;
         rep_act_r   <= 1'b0;
         rep_run_r   <= 1'b0;
         rep_cnt_r   <= {REP_W{1'b0}};
         blink_cnt_r <= 2'd0;
         blink_off_r <= 1'b0;
         secen_r     <= 1'b0;
         secclr_r    <= 1'b0;
         mininc_r    <= 1'b0;
         hourinc_r   <= 1'b0;
         blankh_r    <= 1'b0;
         blankm_r    <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         mode_prev_r <= MODE;
         up_prev_r   <= UP;
         rep_act_r   <= rep_act_next_s;
         rep_run_r   <= rep_run_next_s;
         rep_cnt_r   <= rep_cnt_next_s;
         blink_cnt_r <= blink_cnt_next_s;
         blink_off_r <= blink_off_next_s;
         secen_r     <= sectick_s && (state_r == ST_RUN) && (state_next_s == ST_RUN);
         secclr_r    <= clr_s;
         mininc_r    <= inc_s && (state_r == ST_SETM);
         hourinc_r   <= inc_s && (state_r == ST_SETH);
         blankh_r    <= (state_next_s == ST_SETH) && blink_off_next_s;
         blankm_r    <= (state_next_s == ST_SETM) && blink_off_next_s;
      end
   end

   assign SECEN   = secen_r;
   assign SECCLR  = secclr_r;
   assign MININC  = mininc_r;
   assign HOURINC = hourinc_r;
   assign BLANKH  = blankh_r;
   assign BLANKM  = blankm_r;
   assign STATE   = state_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DIV=16, REP_DLY=4, REP_PER=1.
// Output vector bits: [7:6] STATE, [5] SECEN, [4] SECCLR, [3] MININC, [2] HOURINC, [1] BLANKH, [0] BLANKM.
module tb_clock_set_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       MODE = 1'b0;
   logic       UP = 1'b0;
   logic       SECEN, SECCLR, MININC, HOURINC, BLANKH, BLANKM;
   logic [1:0] STATE;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic       mode;
      logic       up;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t tbl [13];

   clock_set_ctrl #(.DIV(16), .REP_DLY(4), .REP_PER(1)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .MODE    (MODE),
      .UP      (UP),
      .SECEN   (SECEN),
      .SECCLR  (SECCLR),
      .MININC  (MININC),
      .HOURINC (HOURINC),
      .BLANKH  (BLANKH),
      .BLANKM  (BLANKM),
      .STATE   (STATE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] outs();
      return {STATE, SECEN, SECCLR, MININC, HOURINC, BLANKH, BLANKM};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   initial begin
      int pulses;
      logic [7:0] e;

      tbl = '{
         '{1'b1, 1'b0, 8'h40, "mode_to_seth"},
         '{1'b0, 1'b0, 8'h40, "seth_idle"},
         '{1'b0, 1'b1, 8'h44, "seth_up_hourinc"},
         '{1'b0, 1'b0, 8'h40, "seth_up_release"},
         '{1'b0, 1'b0, 8'h40, "seth_blink_on_a"},
         '{1'b0, 1'b0, 8'h40, "seth_blink_on_b"},
         '{1'b0, 1'b0, 8'h40, "seth_blink_on_c"},
         '{1'b0, 1'b0, 8'h40, "seth_blink_on_d"},
         '{1'b0, 1'b0, 8'h40, "seth_blink_on_e"},
         '{1'b0, 1'b0, 8'h42, "seth_blink_off_a"},
         '{1'b0, 1'b0, 8'h42, "seth_blink_off_b"},
         '{1'b1, 1'b1, 8'h80, "mode_up_same_cycle"},
         '{1'b0, 1'b0, 8'h80, "setm_idle"}
      };

      // Reset state
      for (int i = 0; i < 3; i++) step();
      check("reset_outputs", int'(outs()), 8'h00);
      RST = 1'b0;
      cyc = 0;

      // RUN: SECEN once every 16 cycles, one cycle wide; UP toggling is ignored
      for (int i = 0; i < 64; i++) begin
         UP = (i % 5 == 2);
         step();
         check("run_secen", int'(outs()), (cyc % 16 == 0) ? 8'h20 : 8'h00);
      end
      UP = 1'b0;

      // Table: enter SETH, short press, blink, simultaneous MODE+UP
      for (int i = 0; i < 13; i++) begin
         MODE = tbl[i].mode;
         UP   = tbl[i].up;
         step();
         check(tbl[i].name, int'(outs()), int'(tbl[i].exp));
      end

      // SETM, UP held 24 cycles: edge pulse at 78, first repeat 4 subticks later (86), then every 2 cycles
      UP = 1'b1;
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         e = ((cyc == 78) || (cyc >= 86 && cyc % 2 == 0)) ? 8'h08 : 8'h00;
         if (MININC) pulses++;
         check("setm_hold_repeat", int'(outs() & 8'h2C), int'(e));
      end
      check("setm_hold_pulse_count", pulses, 9);
      UP = 1'b0;
      step();
      check("setm_release", int'(outs() & 8'h2C), 8'h00);

      // SETM -> RUN: one SECCLR, then SECEN exactly 16 cycles later
      MODE = 1'b1;
      step();
      check("secclr_pulse", int'(outs()), 8'h10);
      MODE = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         check("secen_after_clr", int'(outs()), (i == 15) ? 8'h20 : 8'h00);
      end

      // MODE edge while UP held cancels the repeat
      MODE = 1'b1;
      step();
      check("run_to_seth", int'(outs()), 8'h40);
      MODE = 1'b0;
      UP = 1'b1;
      step();
      check("seth_press", int'(outs()), 8'h44);
      step();
      step();
      MODE = 1'b1;
      step();
      check("mode_while_held", int'(outs()), 8'h80);
      MODE = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check("no_repeat_after_mode", int'(outs() & 8'h2C), 8'h00);
      end

      // Reset during SETM with UP held
      UP = 1'b0;
      step();
      UP = 1'b1;
      step();
      check("setm_fresh_press", int'(outs()), 8'h88);
      step();
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("reset_mid_set", int'(outs()), 8'h00);
      end
      RST = 1'b0;
      cyc = 0;
      for (int i = 0; i < 16; i++) begin
         UP = (i % 2 == 1);
         step();
         check("run_after_reset", int'(outs()), (cyc == 16) ? 8'h20 : 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
